// File: rtl/pipeline_ctrl.sv
// Pipeline control FSM: stalls, branch/mret redirects, and exception drain/trap/halt sequencing.
// Outputs are combinational from state and inputs; epc, cause, halted and the drain counter are registered.
module pipeline_ctrl #(
  parameter int unsigned DRAIN_CYCLES = 2,
  parameter logic [31:0] CAUSE_ECALL  = 32'd11,
  parameter logic [31:0] CAUSE_BREAK  = 32'd3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hazard_stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        mret,
  input  logic [31:0] mepc,
  input  logic [31:0] mtvec,
  input  logic        env_exception,
  input  logic        bp_exception,
  input  logic [31:0] id_pc,
  input  logic        resume,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        trap_commit,
  output logic [31:0] epc,
  output logic [31:0] cause,
  output logic        halted
);

  typedef enum logic [1:0] {RUN, DRAIN, TRAP, HALT} state_t;

  localparam logic [2:0] DRAIN_INIT = 3'(DRAIN_CYCLES);

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] cause_q, cause_d;
  logic        halted_q, halted_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= RUN;
      cnt_q    <= 3'd0;
      epc_q    <= 32'd0;
      cause_q  <= 32'd0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      epc_q    <= epc_d;
      cause_q  <= cause_d;
      halted_q <= halted_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    epc_d          = epc_q;
    cause_d        = cause_q;
    halted_d       = halted_q;
    pc_en          = 1'b0;
    ifid_en        = 1'b0;
    ifid_flush     = 1'b0;
    idex_flush     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    trap_commit    = 1'b0;

    case (state_q)
      RUN: begin
        if (env_exception || bp_exception) begin
          idex_flush = 1'b1;
          epc_d      = id_pc;
          cause_d    = env_exception ? CAUSE_ECALL : CAUSE_BREAK;
          cnt_d      = DRAIN_INIT;
          state_d    = DRAIN;
        end else if (hazard_stall) begin
          idex_flush = 1'b1;
        end else if (mret || branch_taken) begin
          pc_en          = 1'b1;
          ifid_en        = 1'b1;
          ifid_flush     = 1'b1;
          redirect_valid = 1'b1;
          redirect_pc    = mret ? mepc : branch_target;
        end else begin
          pc_en   = 1'b1;
          ifid_en = 1'b1;
        end
      end

      DRAIN: begin
        idex_flush = 1'b1;
        cnt_d      = cnt_q - 3'd1;
        // Breakpoints park the core instead of vectoring to mtvec.
        if (cnt_q == 3'd1) begin
          if (cause_q == CAUSE_ECALL) begin
            state_d = TRAP;
          end else begin
            state_d  = HALT;
            halted_d = 1'b1;
          end
        end
      end

      TRAP: begin
        trap_commit    = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = mtvec & 32'hFFFF_FFFC;
        ifid_flush     = 1'b1;
        idex_flush     = 1'b1;
        pc_en          = 1'b1;
        ifid_en        = 1'b1;
        state_d        = RUN;
      end

      HALT: begin
        idex_flush = 1'b1;
        if (resume) begin
          pc_en          = 1'b1;
          redirect_valid = 1'b1;
          redirect_pc    = epc_q + 32'd4;
          ifid_flush     = 1'b1;
          halted_d       = 1'b0;
          state_d        = RUN;
        end
      end

      default: state_d = RUN;
    endcase

    // Reset forces safe outputs immediately, independent of the clock.
    if (rst) begin
      pc_en          = 1'b0;
      ifid_en        = 1'b0;
      ifid_flush     = 1'b1;
      idex_flush     = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = 32'd0;
      trap_commit    = 1'b0;
    end
  end

  assign epc    = epc_q;
  assign cause  = cause_q;
  assign halted = halted_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios plus randomized traffic
// compared against a behavioural model of the control rules.
module tb_pipeline_ctrl;

  localparam int          DRAIN = 2;
  localparam logic [31:0] C_ENV = 32'd11;
  localparam logic [31:0] C_BRK = 32'd3;

  logic        clk = 1'b0;
  logic        rst;
  logic        hazard_stall, branch_taken, mret, env_exception, bp_exception, resume;
  logic [31:0] branch_target, mepc, mtvec, id_pc;
  logic        pc_en, ifid_en, ifid_flush, idex_flush, redirect_valid, trap_commit, halted;
  logic [31:0] redirect_pc, epc, cause;

  pipeline_ctrl dut (
    .clk(clk), .rst(rst), .hazard_stall(hazard_stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .mret(mret), .mepc(mepc), .mtvec(mtvec),
    .env_exception(env_exception), .bp_exception(bp_exception), .id_pc(id_pc),
    .resume(resume), .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
    .idex_flush(idex_flush), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .trap_commit(trap_commit), .epc(epc), .cause(cause), .halted(halted)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: remaining drain cycles, a pending trap cycle, and the halted flag.
  int          drain_left;
  bit          trap_now;
  bit          m_halted;
  logic [31:0] m_epc, m_cause;

  logic [102:0] exp_v, mask_v, act_v;

  task automatic model_reset();
    drain_left = 0;
    trap_now   = 0;
    m_halted   = 0;
    m_epc      = 32'd0;
    m_cause    = 32'd0;
  endtask

  task automatic model_eval();
    logic e_pc, e_ie, e_if, e_xf, e_rv, e_tc;
    logic [31:0] e_rpc;
    logic k_pc, k_ie;
    logic [31:0] k_rpc;
    {e_pc, e_ie, e_if, e_xf, e_rv, e_tc} = 6'b0;
    e_rpc = 32'd0;
    k_pc  = 1'b1;
    k_ie  = 1'b1;
    k_rpc = 32'hFFFF_FFFF;
    if (rst) begin
      e_if = 1'b1;
      e_xf = 1'b1;
    end else if (trap_now) begin
      e_tc = 1'b1; e_rv = 1'b1; e_rpc = {mtvec[31:2], 2'b00};
      e_if = 1'b1; e_xf = 1'b1; e_pc = 1'b1; k_ie = 1'b0;
    end else if (drain_left > 0) begin
      e_xf = 1'b1;
    end else if (m_halted) begin
      e_xf = 1'b1;
      if (resume) begin
        e_rv = 1'b1; e_rpc = m_epc + 32'd4; e_if = 1'b1; k_pc = 1'b0; k_ie = 1'b0;
      end
    end else if (env_exception || bp_exception || hazard_stall) begin
      e_xf = 1'b1;
    end else if (mret || branch_taken) begin
      e_rv = 1'b1; e_rpc = mret ? mepc : branch_target; e_if = 1'b1; e_pc = 1'b1; k_ie = 1'b0;
    end else begin
      e_pc = 1'b1; e_ie = 1'b1;
    end
    if (!e_rv && !rst) k_rpc = 32'd0;
    exp_v  = {e_pc, e_ie, e_if, e_xf, e_rv, e_tc, m_halted, e_rpc, m_epc, m_cause};
    mask_v = {k_pc, k_ie, 5'b11111, k_rpc, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
  endtask

  task automatic model_advance();
    if (rst) begin
      model_reset();
    end else if (trap_now) begin
      trap_now = 0;
    end else if (drain_left > 0) begin
      drain_left--;
      if (drain_left == 0) begin
        if (m_cause == C_ENV) trap_now = 1;
        else m_halted = 1;
      end
    end else if (m_halted) begin
      if (resume) m_halted = 0;
    end else if (env_exception || bp_exception) begin
      m_epc      = id_pc;
      m_cause    = env_exception ? C_ENV : C_BRK;
      drain_left = DRAIN;
    end
  endtask

  // Inputs are driven right after the falling edge; outputs are sampled 1 time unit later.
  task automatic step();
    #1;
    if (rst) model_reset();
    model_eval();
    act_v = {pc_en, ifid_en, ifid_flush, idex_flush, redirect_valid, trap_commit, halted,
             redirect_pc, epc, cause};
  endtask

  task automatic tick();
    @(posedge clk);
    model_advance();
    @(negedge clk);
  endtask

  task automatic idle();
    hazard_stall = 0; branch_taken = 0; mret = 0;
    env_exception = 0; bp_exception = 0; resume = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    branch_taken = 1; branch_target = 32'h1234; mepc = 32'h88; mtvec = 32'h0; id_pc = 32'h10;
    step();
    total++;
    if ((act_v & mask_v) !== (exp_v & mask_v)) begin
      bad++; $display("[TB] FAIL reset_model act=%h exp=%h", act_v, exp_v);
    end
    total++;
    if ({pc_en, ifid_en, ifid_flush, idex_flush, redirect_valid, trap_commit} !== 6'b001100) begin
      bad++; $display("[TB] FAIL reset_flags act=%b exp=001100",
                      {pc_en, ifid_en, ifid_flush, idex_flush, redirect_valid, trap_commit});
    end
    tick();
    rst = 1'b0;
    idle();
    step();
    total++;
    if ((act_v & mask_v) !== (exp_v & mask_v)) begin
      bad++; $display("[TB] FAIL reset_release act=%h exp=%h", act_v, exp_v);
    end
    tick();
  endtask

  task automatic test_stall();
    hazard_stall = 1;
    step();
    total++;
    if ({pc_en, ifid_en, idex_flush} !== 3'b001) begin
      bad++; $display("[TB] FAIL stall act=%b exp=001", {pc_en, ifid_en, idex_flush});
    end
    tick();
    idle();
    step();
    total++;
    if ((act_v & mask_v) !== (exp_v & mask_v)) begin
      bad++; $display("[TB] FAIL stall_after act=%h exp=%h", act_v, exp_v);
    end
    tick();
  endtask

  task automatic test_stall_branch();
    hazard_stall = 1; branch_taken = 1; branch_target = 32'h100;
    step();
    total++;
    if (redirect_valid !== 1'b0) begin
      bad++; $display("[TB] FAIL stall_branch_rv act=%b exp=0", redirect_valid);
    end
    tick();
    hazard_stall = 0;
    step();
    total++;
    if ({redirect_valid, ifid_flush, redirect_pc} !== {2'b11, 32'h100}) begin
      bad++; $display("[TB] FAIL branch act=%b%b %h exp=11 00000100",
                      redirect_valid, ifid_flush, redirect_pc);
    end
    tick();
    mret = 1; mepc = 32'h0000_0ABC; branch_target = 32'h200;
    step();
    total++;
    if ({redirect_valid, redirect_pc} !== {1'b1, 32'h0000_0ABC}) begin
      bad++; $display("[TB] FAIL mret_priority act=%b %h exp=1 00000abc", redirect_valid, redirect_pc);
    end
    tick();
    idle();
  endtask

  task automatic test_ecall();
    id_pc = 32'h40; mtvec = 32'h203; env_exception = 1;
    step();
    total++;
    if ((act_v & mask_v) !== (exp_v & mask_v)) begin
      bad++; $display("[TB] FAIL ecall_enter act=%h exp=%h", act_v, exp_v);
    end
    tick();
    idle();
    for (int i = 0; i < DRAIN; i++) begin
      branch_taken = 1; resume = 1;
      step();
      total++;
      if ({redirect_valid, trap_commit, idex_flush, pc_en} !== 4'b0010) begin
        bad++; $display("[TB] FAIL ecall_drain%0d act=%b exp=0010", i,
                        {redirect_valid, trap_commit, idex_flush, pc_en});
      end
      tick();
    end
    idle();
    step();
    total++;
    if ({trap_commit, redirect_valid, redirect_pc, epc, cause} !== {2'b11, 32'h200, 32'h40, 32'd11}) begin
      bad++; $display("[TB] FAIL ecall_trap act=%b%b %h %h %0d exp=11 00000200 00000040 11",
                      trap_commit, redirect_valid, redirect_pc, epc, cause);
    end
    tick();
    step();
    total++;
    if ((act_v & mask_v) !== (exp_v & mask_v) || trap_commit !== 1'b0) begin
      bad++; $display("[TB] FAIL ecall_return act=%h exp=%h", act_v, exp_v);
    end
    tick();
  endtask

  task automatic test_both();
    id_pc = 32'h80; mtvec = 32'h400; env_exception = 1; bp_exception = 1;
    step();
    tick();
    idle();
    for (int i = 0; i < DRAIN + 2; i++) begin
      step();
      total++;
      if ((act_v & mask_v) !== (exp_v & mask_v) || cause !== 32'd11 || halted !== 1'b0) begin
        bad++; $display("[TB] FAIL both_c%0d act=%h exp=%h", i, act_v, exp_v);
      end
      if (i == DRAIN) begin
        total++;
        if (trap_commit !== 1'b1) begin
          bad++; $display("[TB] FAIL both_trap act=%b exp=1", trap_commit);
        end
      end
      tick();
    end
  endtask

  task automatic test_break_wrap();
    id_pc = 32'hFFFF_FFFC; bp_exception = 1;
    step();
    tick();
    idle();
    for (int i = 0; i < DRAIN; i++) begin
      step();
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      branch_taken = 1; mret = 1; env_exception = 1;
      step();
      total++;
      if ({halted, redirect_valid, trap_commit, pc_en} !== 4'b1000 || cause !== C_BRK) begin
        bad++; $display("[TB] FAIL halt_hold%0d act=%b %0d exp=1000 3", i,
                        {halted, redirect_valid, trap_commit, pc_en}, cause);
      end
      tick();
    end
    idle();
    resume = 1;
    step();
    total++;
    if ({redirect_valid, ifid_flush, redirect_pc} !== {2'b11, 32'h0}) begin
      bad++; $display("[TB] FAIL resume_wrap act=%b%b %h exp=11 00000000",
                      redirect_valid, ifid_flush, redirect_pc);
    end
    tick();
    resume = 0;
    step();
    total++;
    if (halted !== 1'b0 || (act_v & mask_v) !== (exp_v & mask_v)) begin
      bad++; $display("[TB] FAIL resume_clear act=%h exp=%h", act_v, exp_v);
    end
    tick();
  endtask

  task automatic test_reset_mid_drain();
    id_pc = 32'h60; env_exception = 1;
    step();
    tick();
    idle();
    step();
    tick();
    rst = 1;
    step();
    total++;
    if ({trap_commit, pc_en, ifid_en, ifid_flush, idex_flush, redirect_valid} !== 6'b000110 ||
        {epc, cause, halted} !== 65'd0) begin
      bad++; $display("[TB] FAIL reset_mid_drain act=%h exp=%h", act_v, exp_v);
    end
    tick();
    rst = 0;
    for (int i = 0; i < DRAIN + 2; i++) begin
      step();
      total++;
      if ((act_v & mask_v) !== (exp_v & mask_v) || trap_commit !== 1'b0) begin
        bad++; $display("[TB] FAIL reset_after%0d act=%h exp=%h", i, act_v, exp_v);
      end
      tick();
    end
  endtask

  task automatic test_random();
    logic prev_tc;
    prev_tc = 1'b0;
    for (int i = 0; i < 400; i++) begin
      rst           = ($urandom_range(0, 59) == 0);
      hazard_stall  = ($urandom_range(0, 3) == 0);
      branch_taken  = ($urandom_range(0, 2) == 0);
      mret          = ($urandom_range(0, 5) == 0);
      env_exception = ($urandom_range(0, 11) == 0);
      bp_exception  = ($urandom_range(0, 11) == 0);
      resume        = ($urandom_range(0, 3) == 0);
      branch_target = $urandom;
      mepc          = $urandom;
      mtvec         = $urandom;
      id_pc         = $urandom;
      step();
      total++;
      if ((act_v & mask_v) !== (exp_v & mask_v) || (prev_tc && trap_commit)) begin
        bad++; $display("[TB] FAIL random%0d act=%h exp=%h", i, act_v, exp_v);
      end
      prev_tc = trap_commit;
      tick();
    end
    rst = 0;
    idle();
  endtask

  initial begin
    model_reset();
    rst = 1'b1;
    idle();
    branch_target = 0; mepc = 0; mtvec = 0; id_pc = 0;
    @(negedge clk);
    test_reset();
    test_stall();
    test_stall_branch();
    test_ecall();
    test_both();
    test_break_wrap();
    test_reset_mid_drain();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Parameter: DRAIN_CYCLES, default 2; cycles to wait for older instructions to retire before a trap. Legal range 1..7.
REQ-003 Parameter: CAUSE_ECALL, default 32'd11; mcause value for an environment exception.
REQ-004 Parameter: CAUSE_BREAK, default 32'd3; mcause value for a breakpoint.
REQ-005 Ports, in order: name, direction, width, meaning.
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- hazard_stall  in  1  load-use or branch-RAW stall from hazard detection.
- branch_taken  in  1  branch or jump in ID resolved taken.
- branch_target  in  32  target of that branch or jump.
- mret  in  1  mret in ID.
- mepc  in  32  CSR mepc.
- mtvec  in  32  CSR mtvec.
- env_exception  in  1  ecall in ID.
- bp_exception  in  1  ebreak in ID.
- id_pc  in  32  PC of the instruction in ID.
- resume  in  1  debug resume pulse.
- pc_en  out  1  PC register enable.
- ifid_en  out  1  IF/ID register enable.
- ifid_flush  out  1  IF/ID bubble insert.
- idex_flush  out  1  ID/EX bubble insert.
- redirect_valid  out  1  PC takes redirect_pc.
- redirect_pc  out  32  next fetch address.
- trap_commit  out  1  one-cycle pulse; CSR writes epc and cause.
- epc  out  32  latched exception PC.
- cause  out  32  latched cause.
- halted  out  1  core halted on ebreak.

Function
REQ-006 The FSM SHALL have four states: RUN, DRAIN, TRAP and HALT. It SHALL use a 3-bit drain counter and registered epc, cause and halted. All other outputs SHALL be combinational from the state and the inputs.
REQ-007 RUN priority SHALL be: exception, then hazard_stall, then mret, then branch_taken, then idle. branch_taken and mret SHALL be ignored while hazard_stall=1.
REQ-008 RUN idle SHALL drive pc_en=1 and ifid_en=1, with all flushes 0 and redirect_valid=0.
REQ-009 RUN with hazard_stall SHALL drive pc_en=0, ifid_en=0 and idex_flush=1.
REQ-010 RUN with mret or a taken branch SHALL drive redirect_valid=1, redirect_pc=mepc or branch_target respectively, ifid_flush=1 and pc_en=1, with zero added latency.
REQ-011 RUN with env_exception or bp_exception SHALL apply the following:
- drive pc_en=0, ifid_en=0 and idex_flush=1;
- latch epc=id_pc;
- latch cause=CAUSE_ECALL if env_exception=1, else CAUSE_BREAK (env wins if both are asserted);
- load counter=DRAIN_CYCLES;
- move to DRAIN.
REQ-012 DRAIN SHALL hold pc_en=0, ifid_en=0 and idex_flush=1, and decrement the counter each cycle. When counter==1, it SHALL go to TRAP if cause==CAUSE_ECALL, else to HALT. DRAIN therefore lasts exactly DRAIN_CYCLES cycles.
REQ-013 TRAP SHALL last one cycle and drive:
- trap_commit=1;
- redirect_valid=1 with redirect_pc={mtvec[31:2],2'b00};
- ifid_flush=1, idex_flush=1 and pc_en=1.
It SHALL then return to RUN.
REQ-014 HALT SHALL set halted=1 and hold pc_en=0, ifid_en=0 and idex_flush=1.
REQ-015 On resume in HALT, the block SHALL drive redirect_valid=1, redirect_pc=epc+4 (mod 2^32) and ifid_flush=1, clear halted on the next edge, and return to RUN.
REQ-016 The exception, branch, mret, hazard_stall and resume inputs SHALL be ignored outside their owning state. resume outside HALT SHALL have no effect.
REQ-017 trap_commit SHALL never assert for two consecutive cycles. redirect_valid SHALL never assert in DRAIN.

Reset
REQ-018 While rst=1, the block SHALL drive:
- state=RUN, counter=0;
- epc=0, cause=0, halted=0;
- pc_en=0, ifid_en=0;
- ifid_flush=1, idex_flush=1;
- redirect_valid=0, redirect_pc=0, trap_commit=0.
REQ-019 rst asserted in any state, including mid-DRAIN or HALT, SHALL abort immediately with no trap_commit. The first edge after release SHALL see RUN idle behaviour.

Verification
REQ-020 hazard_stall=1 for 1 cycle in RUN -> pc_en=0, ifid_en=0, idex_flush=1 that cycle; idle values the next cycle.
REQ-021 hazard_stall=1 and branch_taken=1 with branch_target=0x100 -> redirect_valid=0; then branch_taken alone -> redirect_valid=1, redirect_pc=0x100, ifid_flush=1.
REQ-022 env_exception with id_pc=0x40, mtvec=0x203, DRAIN_CYCLES=2 -> 2 DRAIN cycles, then one TRAP cycle with trap_commit=1, redirect_pc=0x200, epc=0x40, cause=11; then RUN.
REQ-023 env_exception and bp_exception together -> cause=11 and the sequence ends in TRAP, not HALT.
REQ-024 bp_exception with id_pc=0xFFFFFFFC -> halted=1 after drain; resume -> redirect_pc=0x00000000 (wrap), halted=0 the next cycle.
REQ-025 rst pulse in the second DRAIN cycle -> trap_commit stays 0 and all outputs take reset values asynchronously.
